instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Controller that fills the instruction memory from a byte stream, such as the debug UART receiver, then hands the program to the pipeline.
- Assembles 4 bytes into a 32-bit instruction and writes it at consecutive word addresses, driving the memory's write-mode control.
- Starts the PC on command and stops it when the memory flags the HALT instruction.
- Sits between the debug/UART unit, instructionMemory and the PC stage.

Parameters:
- NB_DATA, 32: instruction width.
- NB_BYTE, 8: input byte width.
- MEM_DEPTH, 256: instruction memory depth in words.
- NB_ADDR, 32: address width driven to memory; value is a word index.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_byte  in  NB_BYTE  incoming program byte.
- i_byteValid  in  1  single-cycle strobe; i_byte is valid.
- o_byteReady  out  1  loader accepts bytes; high only in LOAD.
- i_start  in  1  pulse; begin execution from READY.
- i_clear  in  1  pulse; from DONE or READY, return to LOAD for a new program.
- i_haltSignal  in  1  HALT flag from the instruction memory during execution.
- o_pcWrite  out  1  memory write mode; drives memory i_pcWrite.
- o_address  out  NB_ADDR  memory write address (word index).
- o_instruction  out  NB_DATA  assembled word to memory.
- o_pcEnable  out  1  PC/pipeline advance enable.
- o_loaded  out  1  program stored, waiting for start.
- o_done  out  1  execution finished by HALT.
- o_error  out  1  memory filled without a HALT word.

Behaviour:
- States: LOAD, WRITE, READY, RUN, DONE.
- Reset, asynchronous with i_reset=0:
  - state=LOAD, byte counter=0, address=0, shift register=0.
  - o_pcWrite=1, o_byteReady=1, o_pcEnable=0, o_loaded=0, o_done=0, o_error=0, o_address=0, o_instruction=0.
- LOAD:
  - On a clock edge with i_byteValid=1, the byte shifts in MSB-first: word = {word[23:0], i_byte}.
  - The byte counter increments.
  - On the 4th byte, the counter wraps to 0 and the next state is WRITE.
  - i_byteValid when o_byteReady=0 is ignored; the byte is dropped.
- WRITE (exactly 1 cycle):
  - o_byteReady=0. o_address and o_instruction hold the word; o_pcWrite=1, so memory captures the word on this edge.
  - Next state:
    - If word[31:26]==6'b111111 (HALT): READY; o_loaded=1. The address is not incremented.
    - Else if address==MEM_DEPTH-1: READY; o_loaded=1, o_error=1.
    - Else: address+1, back to LOAD.
  - Write latency: the 4th byte is accepted at edge N; the memory write occurs at edge N+1.
- READY:
  - o_pcWrite=0, so memory switches to read mode.
  - i_start → RUN.
  - i_clear → LOAD with address=0, o_loaded=0, o_error=0.
  - If both i_start and i_clear are high in the same cycle, i_clear wins.
- RUN:
  - o_pcEnable=1.
  - When i_haltSignal=1 is sampled: o_pcEnable=0 from the next cycle, state DONE, o_done=1. The HALT instruction is not executed past fetch.
  - i_start and i_clear are ignored in RUN.
- DONE:
  - o_pcEnable=0.
  - i_clear → LOAD with address=0, o_done=0, o_loaded=0, o_error=0.
  - i_start is ignored.
- Reset mid-operation: any state returns to the reset values immediately; a partially assembled word is discarded.
- o_address is always the registered address counter. o_instruction is the registered assembled word.

Optional Feature:
- Macro: INSTR_MEM_LOADER_STEP_EN.
- When defined:
  - Adds input i_step.
  - While in READY, each i_step pulse gives exactly one cycle of o_pcEnable=1; the state stays READY.
  - i_haltSignal sampled during a step cycle → DONE.
- When undefined: no i_step port; execution is continuous only.

Decomposition:
- Package instr_mem_loader_pkg holds:
  - State encoding: LOAD=0, WRITE=1, READY=2, RUN=3, DONE=4 (3 bits).
  - HALT_OPCODE=6'b111111.
  - BYTES_PER_WORD=4.
- Sub-module word_assembler:
  - Shift register plus 2-bit byte counter.
  - Inputs: byte, valid, clear.
  - Outputs: word, word_done pulse.
- The FSM, address counter and run control stay in the top module.

Test Plan:
- Load: send bytes 8C,22,00,04 / 00,49,60,23 / FC,00,00,00. Expect:
  - Writes at addresses 0, 1, 2 with 0x8C220004, 0x00496023, 0xFC000000.
  - o_loaded=1, o_pcWrite=0, o_error=0 afterwards.
- Run: after that load, pulse i_start and assert i_haltSignal 3 cycles later. Expect:
  - o_pcEnable high for exactly 3 cycles.
  - Then o_done=1 and o_pcEnable=0.
- Overflow: with MEM_DEPTH=4, send 4 non-HALT words. Expect:
  - The 4th write lands at address 3.
  - READY with o_error=1, o_loaded=1.
- Dropped byte: pulse i_byteValid during WRITE and during READY. Expect no change to the word or the byte counter.
- Reset mid-load: assert i_reset low after 2 bytes, then send FC,00,00,00. Expect a single write of 0xFC000000 at address 0.
- Clear: from DONE, pulse i_clear together with i_start. Expect:
  - State LOAD, address 0, all flags 0, o_pcEnable stays 0.
  - With INSTR_MEM_LOADER_STEP_EN defined: 2 i_step pulses in READY give exactly 2 o_pcEnable cycles.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader_pkg
// Brief    : Shared state encoding and constants for the instruction-memory
//            loader (byte-stream program fill, then PC run control).
// Revision : 1.0  initial release
// ============================================================================
package instr_mem_loader_pkg;

   // Loader controller states
   typedef enum logic [2:0] {
      ST_LOAD  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READY = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Opcode field value that marks the end of a program
   localparam logic [5:0] HALT_OPCODE    = 6'b111111;

   // Bytes assembled into one instruction word
   localparam int         BYTES_PER_WORD = 4;

endpackage : instr_mem_loader_pkg
`default_nettype wire

// File: rtl/instr_mem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : word_assembler
// Brief    : Shifts incoming bytes MSB-first into a word and pulses
//            o_wordDone combinationally on the byte that completes it.
// Revision : 1.0  initial release
// ============================================================================
module word_assembler
   import instr_mem_loader_pkg::*;
#(
   parameter int NB_DATA = 32,
   parameter int NB_BYTE = 8
)(
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NB_BYTE-1:0] i_byte,
   input  logic               i_valid,
   input  logic               i_clear,
   output logic [NB_DATA-1:0] o_word,
   output logic               o_wordDone
);

   logic [NB_DATA-1:0] r_word;
   logic [1:0]         r_count;

   // Completing byte: counter is on the last slot and a byte arrives
   assign o_wordDone = i_valid && (r_count == 2'(BYTES_PER_WORD - 1));
   assign o_word     = r_word;

   // Shift register and byte counter; counter wraps to 0 after the 4th byte
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_word  <= '0;
         r_count <= 2'd0;
      end else if (i_clear) begin
         r_word  <= '0;
         r_count <= 2'd0;
      end else if (i_valid) begin
         r_word  <= {r_word[NB_DATA-NB_BYTE-1:0], i_byte};
         r_count <= r_count + 2'd1;
      end
   end

endmodule : word_assembler
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Brief    : Fills instruction memory from a byte stream, then starts the PC
//            and stops it when memory flags the HALT instruction.
//            Optional single-step support: define INSTR_MEM_LOADER_STEP_EN.
// Revision : 1.0  initial release
// ============================================================================
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter int NB_DATA   = 32,
   parameter int NB_BYTE   = 8,
   parameter int MEM_DEPTH = 256,
   parameter int NB_ADDR   = 32
)(
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NB_BYTE-1:0] i_byte,
   input  logic               i_byteValid,
   output logic               o_byteReady,
   input  logic               i_start,
   input  logic               i_clear,
`ifdef INSTR_MEM_LOADER_STEP_EN
   input  logic               i_step,
`endif
   input  logic               i_haltSignal,
   output logic               o_pcWrite,
   output logic [NB_ADDR-1:0] o_address,
   output logic [NB_DATA-1:0] o_instruction,
   output logic               o_pcEnable,
   output logic               o_loaded,
   output logic               o_done,
   output logic               o_error
);

   state_t             r_state;
   state_t             w_next;
   logic [NB_ADDR-1:0] r_addr;
   logic               r_loaded;
   logic               r_done;
   logic               r_error;
   logic [NB_DATA-1:0] w_word;
   logic               w_wordDone;
   logic               w_asmValid;
   logic               w_clear;
   logic               w_isHalt;
   logic               w_isLast;
   logic               w_stepHalt;

   // Bytes are only taken while loading; anything else is dropped
   assign w_asmValid = i_byteValid && (r_state == ST_LOAD);
   assign w_clear    = i_clear && ((r_state == ST_READY) || (r_state == ST_DONE));
   assign w_isHalt   = (w_word[NB_DATA-1 -: 6] == HALT_OPCODE);
   assign w_isLast   = (r_addr == NB_ADDR'(MEM_DEPTH - 1));

   word_assembler #(
      .NB_DATA (NB_DATA),
      .NB_BYTE (NB_BYTE)
   ) u_word_assembler (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_byte     (i_byte),
      .i_valid    (w_asmValid),
      .i_clear    (w_clear),
      .o_word     (w_word),
      .o_wordDone (w_wordDone)
   );

`ifdef INSTR_MEM_LOADER_STEP_EN
   logic r_step;

   // A halt seen during a single-step cycle ends execution
   assign w_stepHalt = r_step && i_haltSignal;

   // One enable cycle per step pulse while the controller stays in READY
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_step <= 1'b0;
      end else begin
         r_step <= i_step && (r_state == ST_READY) && (w_next == ST_READY);
      end
   end

   assign o_pcEnable = (r_state == ST_RUN) || r_step;
`else
   assign w_stepHalt = 1'b0;
   assign o_pcEnable = (r_state == ST_RUN);
`endif

   // State register
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= ST_LOAD;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; clear takes priority over start in READY
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_LOAD:  if (w_wordDone)              w_next = ST_WRITE;
         ST_WRITE: if (w_isHalt || w_isLast)    w_next = ST_READY;
                   else                         w_next = ST_LOAD;
         ST_READY: if (i_clear)                 w_next = ST_LOAD;
                   else if (w_stepHalt)         w_next = ST_DONE;
                   else if (i_start)            w_next = ST_RUN;
         ST_RUN:   if (i_haltSignal)            w_next = ST_DONE;
         ST_DONE:  if (i_clear)                 w_next = ST_LOAD;
         default:                               w_next = ST_LOAD;
      endcase
   end

   // Address counter and status flags
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_addr   <= '0;
         r_loaded <= 1'b0;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
      end else if (w_clear) begin
         r_addr   <= '0;
         r_loaded <= 1'b0;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         case (r_state)
            ST_WRITE: begin
               if (w_isHalt || w_isLast) begin
                  r_loaded <= 1'b1;
                  r_error  <= !w_isHalt;
               end else begin
                  r_addr   <= r_addr + NB_ADDR'(1);
               end
            end
            ST_READY: if (w_stepHalt)   r_done <= 1'b1;
            ST_RUN:   if (i_haltSignal) r_done <= 1'b1;
            default:  ;
         endcase
      end
   end

   assign o_byteReady   = (r_state == ST_LOAD);
   assign o_pcWrite     = (r_state == ST_LOAD) || (r_state == ST_WRITE);
   assign o_address     = r_addr;
   assign o_instruction = w_word;
   assign o_loaded      = r_loaded;
   assign o_done        = r_done;
   assign o_error       = r_error;

endmodule : instr_mem_loader
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_loader
// Brief    : Directed self-checking bench for instr_mem_loader
//            (MEM_DEPTH=4 so the overflow path is reachable quickly).
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_mem_loader;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b0;
   logic [7:0]  i_byte = 8'h00;
   logic        i_byteValid = 1'b0;
   logic        i_start = 1'b0;
   logic        i_clear = 1'b0;
   logic        i_step = 1'b0;
   logic        i_haltSignal = 1'b0;
   logic        o_byteReady;
   logic        o_pcWrite;
   logic [31:0] o_address;
   logic [31:0] o_instruction;
   logic        o_pcEnable;
   logic        o_loaded;
   logic        o_done;
   logic        o_error;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [63:0] wq[$];

   instr_mem_loader #(
      .NB_DATA   (32),
      .NB_BYTE   (8),
      .MEM_DEPTH (4),
      .NB_ADDR   (32)
   ) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_byte        (i_byte),
      .i_byteValid   (i_byteValid),
      .o_byteReady   (o_byteReady),
      .i_start       (i_start),
      .i_clear       (i_clear),
`ifdef INSTR_MEM_LOADER_STEP_EN
      .i_step        (i_step),
`endif
      .i_haltSignal  (i_haltSignal),
      .o_pcWrite     (o_pcWrite),
      .o_address     (o_address),
      .o_instruction (o_instruction),
      .o_pcEnable    (o_pcEnable),
      .o_loaded      (o_loaded),
      .o_done        (o_done),
      .o_error       (o_error)
   );

   always #5 i_clk = ~i_clk;

   // Log every memory write (write mode with byte intake closed = WRITE cycle)
   always @(negedge i_clk) begin
      if (i_reset && o_pcWrite && !o_byteReady)
         wq.push_back({o_address, o_instruction});
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_byte      = b;
      i_byteValid = 1'b1;
      @(negedge i_clk);
      i_byteValid = 1'b0;
   endtask

   // Four bytes back to back, then one cycle for WRITE (optionally poking a byte)
   task automatic send_word(input logic [31:0] w, input bit poke);
      for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
      if (poke) send_byte(8'hEE);
      else      @(negedge i_clk);
   endtask

   task automatic pulse_clear_start();
      i_clear = 1'b1;
      i_start = 1'b1;
      @(negedge i_clk);
      i_clear = 1'b0;
      i_start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;

      // ---------------- reset state ----------------
      @(negedge i_clk);
      check("rst_pcWrite",   o_pcWrite,     1);
      check("rst_byteReady", o_byteReady,   1);
      check("rst_pcEnable",  o_pcEnable,    0);
      check("rst_flags",     {o_loaded, o_done, o_error}, 0);
      check("rst_addr",      o_address,     0);
      check("rst_instr",     o_instruction, 0);
      i_reset = 1'b1;
      @(negedge i_clk);

      // ---------------- three-word program load ----------------
      send_word(32'h8C220004, 0);
      send_word(32'h00496023, 0);
      send_word(32'hFC000000, 0);
      check("load_nwrites", wq.size(), 3);
      if (wq.size() == 3) begin
         check("load_w0", wq[0], {32'd0, 32'h8C220004});
         check("load_w1", wq[1], {32'd1, 32'h00496023});
         check("load_w2", wq[2], {32'd2, 32'hFC000000});
      end
      check("load_loaded",  o_loaded,    1);
      check("load_pcWrite", o_pcWrite,   0);
      check("load_error",   o_error,     0);
      check("load_addr",    o_address,   2);
      check("load_ready",   o_byteReady, 0);

      // byte offered in READY is dropped
      send_byte(8'hAA);
      check("drop_ready_instr", o_instruction, 32'hFC000000);

      // ---------------- run until HALT ----------------
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (o_pcEnable) cnt++;
         i_haltSignal = (i == 2);
         @(negedge i_clk);
      end
      i_haltSignal = 1'b0;
      check("run_en_cycles", cnt, 3);
      check("run_done",      o_done, 1);
      check("run_pcEnable",  o_pcEnable, 0);
      // start ignored in DONE
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      @(negedge i_clk);
      check("done_start_ign", {o_done, o_pcEnable}, 2'b10);

      // ---------------- clear + start together from DONE ----------------
      pulse_clear_start();
      check("clr_load",   {o_byteReady, o_pcWrite}, 2'b11);
      check("clr_addr",   o_address, 0);
      check("clr_flags",  {o_loaded, o_done, o_error}, 0);
      check("clr_pcEn",   o_pcEnable, 0);

      // ---------------- overflow: 4 non-HALT words into depth 4 ----------------
      wq.delete();
      send_word(32'h11111111, 0);
      send_word(32'h22222222, 1);   // extra byte during WRITE must be dropped
      send_word(32'h33333333, 0);
      send_word(32'h44444444, 0);
      check("ovf_nwrites", wq.size(), 4);
      if (wq.size() == 4) begin
         check("ovf_w2", wq[2], {32'd2, 32'h33333333});
         check("ovf_w3", wq[3], {32'd3, 32'h44444444});
      end
      check("ovf_flags",   {o_loaded, o_error, o_done}, 3'b110);
      check("ovf_ready",   {o_byteReady, o_pcWrite}, 2'b00);

      // clear wins over start in READY
      pulse_clear_start();
      check("rdy_clr_state", {o_byteReady, o_pcEnable}, 2'b10);
      check("rdy_clr_flags", {o_loaded, o_error, o_address}, 0);

      // ---------------- reset in the middle of a word ----------------
      wq.delete();
      send_byte(8'h12);
      send_byte(8'h34);
      i_reset = 1'b0;
      @(negedge i_clk);
      check("midrst_instr", o_instruction, 0);
      i_reset = 1'b1;
      @(negedge i_clk);
      send_word(32'hFC000000, 0);
      check("midrst_nwrites", wq.size(), 1);
      if (wq.size() == 1)
         check("midrst_w0", wq[0], {32'd0, 32'hFC000000});
      check("midrst_loaded", o_loaded, 1);

`ifdef INSTR_MEM_LOADER_STEP_EN
      // ---------------- single step: two pulses, two enable cycles ----------------
      cnt = 0;
      for (int p = 0; p < 2; p++) begin
         i_step = 1'b1;
         @(negedge i_clk);
         i_step = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (o_pcEnable) cnt++;
            @(negedge i_clk);
         end
      end
      check("step_en_cycles", cnt, 2);
      check("step_still_ready", {o_loaded, o_done, o_byteReady}, 3'b100);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_instr_mem_loader
`default_nettype wire
